// File: rtl/maze_mem_arbiter.sv
// -----------------------------------------------------------------------------
// maze_mem_arbiter
//
// Purpose: shares one single-bit-wide maze memory between the maze solver
// controller (s*) and the host/loader (h*). Each transaction is a fixed
// three-state sequence IDLE -> ACCESS -> RESP, so throughput is one access
// every three cycles. The maze memory is expected to present mDout for the
// address on mLoc by the end of the ACCESS cycle; it is captured on the
// ACCESS->RESP edge.
//
// Handshake (both requester ports): a requester raises xReq with xLoc/xWr/xDin
// stable and keeps them stable until xAck. A request seen in IDLE is accepted;
// xGnt is high for ACCESS and RESP, xAck pulses for the single RESP cycle and
// read data on xDout is valid with xAck (then holds). The requester must drop
// xReq in the ack cycle; a request still high in the following IDLE cycle is a
// new transaction. Dropping xReq after acceptance does not cancel the access.
//
// Configuration macro: MAZE_ARB_RR_EN
//   defined   -> round-robin tie break, pointer favours the requester not
//                granted most recently (solver favoured out of reset)
//   undefined -> fixed priority, solver wins ties
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sReq/sLoc/sWr/sDin       solver request, address, op (1=write), write data
//   sGnt/sAck/sDout          solver grant, completion pulse, read data
//   hReq/hLoc/hWr/hDin       host request side (same semantics as solver)
//   hGnt/hAck/hDout          host response side
//   mLoc/mRd/mWr/mDin/mDout  maze memory address, strobes, write/read data
//   busy                     high whenever the FSM is not IDLE
//   sCnt/hCnt                completed transactions per requester (wrapping)
//   dbgState                 current FSM state (0=IDLE, 1=ACCESS, 2=RESP)
// -----------------------------------------------------------------------------
module maze_mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sReq,
  input  logic [ADDR_W-1:0] sLoc,
  input  logic              sWr,
  input  logic              sDin,
  output logic              sGnt,
  output logic              sAck,
  output logic              sDout,
  input  logic              hReq,
  input  logic [ADDR_W-1:0] hLoc,
  input  logic              hWr,
  input  logic              hDin,
  output logic              hGnt,
  output logic              hAck,
  output logic              hDout,
  output logic [ADDR_W-1:0] mLoc,
  output logic              mRd,
  output logic              mWr,
  output logic              mDin,
  input  logic              mDout,
  output logic              busy,
  output logic [7:0]        sCnt,
  output logic [7:0]        hCnt,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_win;    // 0 = solver owns the transaction, 1 = host
  logic              r_wr;     // latched op of the winner
  logic [ADDR_W-1:0] r_loc;
  logic              r_din;
  logic              r_sDout;
  logic              r_hDout;
  logic [7:0]        r_sCnt;
  logic [7:0]        r_hCnt;
  logic              w_start;
  logic              w_pick;   // winner chosen this IDLE cycle

`ifdef MAZE_ARB_RR_EN
  logic r_ptr;                 // requester favoured on the next tie (0 = solver)
`endif

  // Arbitration: a single requester always wins; only ties consult the policy.
  always_comb begin
    w_start = (r_state == ST_IDLE) && (sReq || hReq);
`ifdef MAZE_ARB_RR_EN
    if (sReq && hReq) w_pick = r_ptr;
    else              w_pick = ~sReq;
`else
    w_pick = ~sReq;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (sReq || hReq) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_win   <= 1'b0;
      r_wr    <= 1'b0;
      r_loc   <= '0;
      r_din   <= 1'b0;
      r_sDout <= 1'b0;
      r_hDout <= 1'b0;
      r_sCnt  <= 8'd0;
      r_hCnt  <= 8'd0;
`ifdef MAZE_ARB_RR_EN
      r_ptr   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      // Address/data are registered at acceptance so mLoc/mDin hold their
      // last driven value once the access is over.
      if (w_start) begin
        r_win <= w_pick;
        r_wr  <= w_pick ? hWr  : sWr;
        r_loc <= w_pick ? hLoc : sLoc;
        r_din <= w_pick ? hDin : sDin;
`ifdef MAZE_ARB_RR_EN
        r_ptr <= ~w_pick;
`endif
      end
      if (r_state == ST_ACCESS && !r_wr) begin
        if (r_win) r_hDout <= mDout;
        else       r_sDout <= mDout;
      end
      if (r_state == ST_RESP) begin
        if (r_win) r_hCnt <= r_hCnt + 8'd1;
        else       r_sCnt <= r_sCnt + 8'd1;
      end
    end
  end

  always_comb begin
    sGnt     = (r_state != ST_IDLE) && !r_win;
    hGnt     = (r_state != ST_IDLE) &&  r_win;
    sAck     = (r_state == ST_RESP) && !r_win;
    hAck     = (r_state == ST_RESP) &&  r_win;
    mRd      = (r_state == ST_ACCESS) && !r_wr;
    mWr      = (r_state == ST_ACCESS) &&  r_wr;
    mLoc     = r_loc;
    mDin     = r_din;
    sDout    = r_sDout;
    hDout    = r_hDout;
    sCnt     = r_sCnt;
    hCnt     = r_hCnt;
    busy     = (r_state != ST_IDLE);
    dbgState = r_state;
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_maze_mem_arbiter: directed bench for maze_mem_arbiter with a small
// behavioural maze memory (combinational read, write on the clock edge).
// Inputs are driven just after the rising edge, outputs sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_maze_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       sReq, sWr, sDin, sGnt, sAck, sDout;
  logic [7:0] sLoc;
  logic       hReq, hWr, hDin, hGnt, hAck, hDout;
  logic [7:0] hLoc;
  logic [7:0] mLoc;
  logic       mRd, mWr, mDin, mDout;
  logic       busy;
  logic [7:0] sCnt, hCnt;
  logic [1:0] dbgState;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- maze memory model ----------------
  logic       mem [256];
  logic       mem_clr;
  logic       pre_we;
  logic [7:0] pre_a;
  logic       pre_d;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 1'b0;
    end else if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (mWr) begin
      mem[mLoc] <= mDin;
    end
  end
  assign mDout = mem[mLoc];

  maze_mem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .sReq(sReq), .sLoc(sLoc), .sWr(sWr), .sDin(sDin),
    .sGnt(sGnt), .sAck(sAck), .sDout(sDout),
    .hReq(hReq), .hLoc(hLoc), .hWr(hWr), .hDin(hDin),
    .hGnt(hGnt), .hAck(hAck), .hDout(hDout),
    .mLoc(mLoc), .mRd(mRd), .mWr(mWr), .mDin(mDin), .mDout(mDout),
    .busy(busy), .sCnt(sCnt), .hCnt(hCnt), .dbgState(dbgState)
  );

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    sReq = 0; sWr = 0; sDin = 0; sLoc = 8'h00;
    hReq = 0; hWr = 0; hDin = 0; hLoc = 8'h00;
  endtask

  task automatic apply_reset();
    rst = 1;
    drive_idle();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic preload(input logic [7:0] a, input logic d);
    pre_we = 1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_we = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    drive_idle();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if ({mRd, mWr} !== 2'b00) begin errors++; $display("FAIL rst_strobes got=%b exp=00", {mRd, mWr}); end
    checks++; if (mLoc !== 8'h00 || mDin !== 1'b0) begin errors++; $display("FAIL rst_mloc got=%h/%b exp=00/0", mLoc, mDin); end
    checks++; if ({sGnt, hGnt, sAck, hAck} !== 4'b0000) begin errors++; $display("FAIL rst_gnt_ack got=%b exp=0000", {sGnt, hGnt, sAck, hAck}); end
    checks++; if ({sDout, hDout} !== 2'b00) begin errors++; $display("FAIL rst_dout got=%b exp=00", {sDout, hDout}); end
    checks++; if (sCnt !== 8'd0 || hCnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", sCnt, hCnt); end
    checks++; if (dbgState !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", dbgState); end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_solver_read();
    sReq = 1; sWr = 0; sLoc = 8'h12; sDin = 0;
    @(negedge clk);  // cycle 0 (IDLE)
    checks++; if (busy !== 1'b0 || mRd !== 1'b0) begin errors++; $display("FAIL srd_c0 busy/mRd got=%b%b exp=00", busy, mRd); end
    @(negedge clk);  // cycle 1 (ACCESS)
    checks++; if (mRd !== 1'b1 || mWr !== 1'b0) begin errors++; $display("FAIL srd_strobe got mRd=%b mWr=%b exp 1/0", mRd, mWr); end
    checks++; if (mLoc !== 8'h12) begin errors++; $display("FAIL srd_mloc got=%h exp=12", mLoc); end
    checks++; if (sGnt !== 1'b1 || hGnt !== 1'b0 || dbgState !== 2'd1) begin errors++; $display("FAIL srd_gnt got s=%b h=%b st=%0d exp 1/0/1", sGnt, hGnt, dbgState); end
    @(negedge clk);  // cycle 2 (RESP)
    checks++; if (sAck !== 1'b1 || hAck !== 1'b0) begin errors++; $display("FAIL srd_ack got s=%b h=%b exp 1/0", sAck, hAck); end
    checks++; if (sDout !== 1'b1) begin errors++; $display("FAIL srd_dout got=%b exp=1", sDout); end
    checks++; if (mRd !== 1'b0 || mLoc !== 8'h12) begin errors++; $display("FAIL srd_resp_mem got mRd=%b mLoc=%h exp 0/12", mRd, mLoc); end
    sReq = 0;
    @(negedge clk);  // cycle 3 (IDLE)
    checks++; if (sCnt !== 8'd1) begin errors++; $display("FAIL srd_cnt got=%0d exp=1", sCnt); end
    checks++; if (sAck !== 1'b0 || busy !== 1'b0 || sDout !== 1'b1) begin errors++; $display("FAIL srd_after got ack=%b busy=%b dout=%b exp 0/0/1", sAck, busy, sDout); end
    @(posedge clk); #1;
  endtask

  task automatic test_host_write();
    hReq = 1; hWr = 1; hLoc = 8'h05; hDin = 1;
    @(negedge clk);  // cycle 0
    @(negedge clk);  // cycle 1
    checks++; if (mWr !== 1'b1 || mRd !== 1'b0 || mDin !== 1'b1 || mLoc !== 8'h05) begin errors++; $display("FAIL hwr_strobe got mWr=%b mRd=%b mDin=%b mLoc=%h exp 1/0/1/05", mWr, mRd, mDin, mLoc); end
    checks++; if (hGnt !== 1'b1 || sGnt !== 1'b0) begin errors++; $display("FAIL hwr_gnt got h=%b s=%b exp 1/0", hGnt, sGnt); end
    @(negedge clk);  // cycle 2
    checks++; if (hAck !== 1'b1 || sAck !== 1'b0 || mWr !== 1'b0) begin errors++; $display("FAIL hwr_ack got hAck=%b sAck=%b mWr=%b exp 1/0/0", hAck, sAck, mWr); end
    hReq = 0; hWr = 0; hDin = 0;
    @(negedge clk);
    checks++; if (hCnt !== 8'd1 || sCnt !== 8'd1) begin errors++; $display("FAIL hwr_cnt got h=%0d s=%0d exp 1/1", hCnt, sCnt); end
    // solver reads the location back
    @(posedge clk); #1;
    sReq = 1; sWr = 0; sLoc = 8'h05;
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++; if (sAck !== 1'b1 || sDout !== 1'b1) begin errors++; $display("FAIL hwr_readback got ack=%b dout=%b exp 1/1", sAck, sDout); end
    sReq = 0;
    @(negedge clk);
    checks++; if (sCnt !== 8'd2) begin errors++; $display("FAIL hwr_scnt got=%0d exp=2", sCnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_tie();
    logic exp_second_host;
`ifdef MAZE_ARB_RR_EN
    exp_second_host = 1'b1;
`else
    exp_second_host = 1'b0;
`endif
    apply_reset();
    sReq = 1; sWr = 0; sLoc = 8'h20;
    hReq = 1; hWr = 0; hLoc = 8'h21;
    @(negedge clk);  // IDLE
    @(negedge clk);  // ACCESS #1
    checks++; if (sGnt !== 1'b1 || hGnt !== 1'b0 || mLoc !== 8'h20) begin errors++; $display("FAIL tie_first got s=%b h=%b mLoc=%h exp 1/0/20", sGnt, hGnt, mLoc); end
    @(negedge clk);  // RESP #1
    checks++; if (sAck !== 1'b1 || hAck !== 1'b0 || sDout !== 1'b0) begin errors++; $display("FAIL tie_ack1 got s=%b h=%b dout=%b exp 1/0/0", sAck, hAck, sDout); end
    @(negedge clk);  // IDLE, both still requesting
    @(negedge clk);  // ACCESS #2
    checks++; if (hGnt !== exp_second_host || sGnt !== ~exp_second_host) begin errors++; $display("FAIL tie_second got s=%b h=%b exp h=%b", sGnt, hGnt, exp_second_host); end
    checks++; if (mLoc !== (exp_second_host ? 8'h21 : 8'h20)) begin errors++; $display("FAIL tie_second_mloc got=%h exp_host=%b", mLoc, exp_second_host); end
    @(negedge clk);  // RESP #2
    checks++; if (hAck !== exp_second_host || sAck !== ~exp_second_host) begin errors++; $display("FAIL tie_ack2 got s=%b h=%b exp h=%b", sAck, hAck, exp_second_host); end
    if (exp_second_host) begin
      checks++; if (hDout !== 1'b1) begin errors++; $display("FAIL tie_hdout got=%b exp=1", hDout); end
    end
    sReq = 0; hReq = 0;
    @(negedge clk);
    checks++; if (sCnt !== (exp_second_host ? 8'd1 : 8'd2) || hCnt !== (exp_second_host ? 8'd1 : 8'd0)) begin errors++; $display("FAIL tie_cnt got s=%0d h=%0d rr=%b", sCnt, hCnt, exp_second_host); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    sReq = 1; sWr = 0; sLoc = 8'h12;
    @(negedge clk);  // IDLE
    @(negedge clk);  // ACCESS
    checks++; if (mRd !== 1'b1) begin errors++; $display("FAIL rmid_access got mRd=%b exp=1", mRd); end
    rst = 1; sReq = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || dbgState !== 2'd0) begin errors++; $display("FAIL rmid_state got busy=%b st=%0d exp 0/0", busy, dbgState); end
    checks++; if (sAck !== 1'b0 || sGnt !== 1'b0 || mRd !== 1'b0 || mWr !== 1'b0) begin errors++; $display("FAIL rmid_outs got ack=%b gnt=%b rd=%b wr=%b exp 0000", sAck, sGnt, mRd, mWr); end
    rst = 0;
    @(negedge clk);
    checks++; if (sAck !== 1'b0 || sCnt !== 8'd0 || hCnt !== 8'd0) begin errors++; $display("FAIL rmid_after got ack=%b s=%0d h=%0d exp 0/0/0", sAck, sCnt, hCnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int last = 0;
    apply_reset();
    sReq = 1; sWr = 0; sLoc = 8'h12;
    for (int cyc = 0; cyc < 1000 && acks < 256; cyc++) begin
      @(negedge clk);
      if (hGnt !== 1'b0) begin checks++; errors++; $display("FAIL b2b_hgnt got=%b exp=0 cyc=%0d", hGnt, cyc); end
      if (sAck === 1'b1) begin
        if (acks > 0) begin
          checks++; if (cyc - last !== 3) begin errors++; $display("FAIL b2b_gap got=%0d exp=3 ack=%0d", cyc - last, acks); end
        end
        checks++; if (sDout !== 1'b1 || sCnt !== acks[7:0]) begin errors++; $display("FAIL b2b_ack got dout=%b cnt=%0d exp 1/%0d", sDout, sCnt, acks[7:0]); end
        last = cyc;
        acks++;
        if (acks == 256) sReq = 0;
      end
    end
    checks++; if (acks != 256) begin errors++; $display("FAIL b2b_count got=%0d exp=256", acks); end
    @(negedge clk);
    checks++; if (sCnt !== 8'd0 || hCnt !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_wrap got s=%0d h=%0d busy=%b exp 0/0/0", sCnt, hCnt, busy); end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1; mem_clr = 1; pre_we = 0; pre_a = 8'h00; pre_d = 0;
    drive_idle();
    @(posedge clk); #1;
    mem_clr = 0;
    preload(8'h12, 1'b1);
    preload(8'h21, 1'b1);
    test_reset();
    test_solver_read();
    test_host_write();
    test_tie();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
